// File: rtl/kule_gfx_pkg.sv
// Shared constants and types for the sprite blitter datapath.
package kule_gfx_pkg;

    localparam int SPRITE_NUM       = 16;
    localparam int SPRITE_W         = 32;
    localparam int SPRITE_H         = 32;
    localparam int SPRITE_ADDR_SIZE = 9;
    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int FB_ADDR_W        = 19;

    localparam int SEL_W  = $clog2(SPRITE_NUM);
    localparam int SRC_AW = SPRITE_ADDR_SIZE + 1;
    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    // Output-space offset: large enough for SPRITE_W*255-1.
    localparam int OFS_W  = 14;
    // Screen position: sign-extended 16-bit origin plus offset, never overflows.
    localparam int POS_W  = 18;

    localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DRAIN
    } blit_state_t;

endpackage

// File: rtl/sprite_raster_counter.sv
// Raster walker over the magnified sprite: output offset (ox, oy) with
// ox fastest, plus the source bitmap address it maps to.
module sprite_raster_counter
    import kule_gfx_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          scale,
    input  logic                step,
    input  logic                clear,
    output logic [OFS_W-1:0]    ox,
    output logic [OFS_W-1:0]    oy,
    output logic [SRC_AW-1:0]   src_addr,
    output logic                last
);

    logic [7:0]       rep_x;
    logic [7:0]       rep_y;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             rep_x_wrap;
    logic             rep_y_wrap;
    logic             col_wrap;

    assign rep_x_wrap = (rep_x == scale - 8'd1);
    assign rep_y_wrap = (rep_y == scale - 8'd1);
    assign col_wrap   = (col == COL_W'(SPRITE_W - 1));
    assign last       = rep_x_wrap && rep_y_wrap && col_wrap &&
                        (row == ROW_W'(SPRITE_H - 1));
    // Source address only moves when col or row moves; repeats reuse it.
    assign src_addr   = SRC_AW'(row) * SRC_AW'(SPRITE_W) + SRC_AW'(col);

    // Advance rep_x -> col -> rep_y -> row, tracking the output offset alongside.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rep_x <= '0;
            rep_y <= '0;
            col   <= '0;
            row   <= '0;
            ox    <= '0;
            oy    <= '0;
        end else if (step) begin
            if (!rep_x_wrap) begin
                rep_x <= rep_x + 8'd1;
                ox    <= ox + OFS_W'(1);
            end else begin
                rep_x <= '0;
                if (!col_wrap) begin
                    col <= col + COL_W'(1);
                    ox  <= ox + OFS_W'(1);
                end else begin
                    col <= '0;
                    ox  <= '0;
                    oy  <= oy + OFS_W'(1);
                    if (!rep_y_wrap) begin
                        rep_y <= rep_y + 8'd1;
                    end else begin
                        rep_y <= '0;
                        row   <= row + ROW_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Pops sprite draw entries and paints magnified, clipped, non-transparent
// pixels into the framebuffer through a two-stage fetch/write pipeline.
module sprite_blitter
    import kule_gfx_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  is_empty,
    input  logic [7:0]            sprite_id,
    input  logic [15:0]           sprite_x,
    input  logic [15:0]           sprite_y,
    input  logic [7:0]            sprite_scale,
    output logic                  dequeue,
    output logic [SEL_W-1:0]      sprite_r0_select,
    output logic [SRC_AW-1:0]     sprite_r0_addr,
    input  logic [3:0]            sprite_r0_data,
    output logic                  fb_w_en,
    output logic [FB_ADDR_W-1:0]  fb_w_addr,
    output logic [3:0]            fb_w_data,
    input  logic                  fb_ready,
    output logic                  busy
);

    localparam logic signed [POS_W-1:0] SCR_W_S = POS_W'(SCREEN_W);
    localparam logic signed [POS_W-1:0] SCR_H_S = POS_W'(SCREEN_H);

    function automatic logic on_screen(input logic signed [POS_W-1:0] px,
                                       input logic signed [POS_W-1:0] py);
        return !px[POS_W-1] && (px < SCR_W_S) && !py[POS_W-1] && (py < SCR_H_S);
    endfunction

    function automatic logic [FB_ADDR_W-1:0] fb_index(input logic signed [POS_W-1:0] px,
                                                      input logic signed [POS_W-1:0] py);
        logic [FB_ADDR_W-1:0] ux;
        logic [FB_ADDR_W-1:0] uy;
        ux = FB_ADDR_W'($unsigned(px));
        uy = FB_ADDR_W'($unsigned(py));
        return uy * FB_ADDR_W'(SCREEN_W) + ux;
    endfunction

    blit_state_t              state;
    logic [SEL_W-1:0]         id_q;
    logic signed [15:0]       x_q;
    logic signed [15:0]       y_q;
    logic [7:0]               scale_q;

    logic [OFS_W-1:0]         ox_p0;
    logic [OFS_W-1:0]         oy_p0;
    logic [SRC_AW-1:0]        src_addr_p0;
    logic                     last_p0;
    logic                     step_p0;
    logic                     clear_p0;
    logic signed [POS_W-1:0]  px_p0;
    logic signed [POS_W-1:0]  py_p0;

    logic signed [POS_W-1:0]  px_p1;
    logic signed [POS_W-1:0]  py_p1;
    logic [SRC_AW-1:0]        src_addr_p1;
    logic                     vld_p1;
    logic                     stall;

    // Stage A: raster walker selects the source pixel for (ox, oy).
    sprite_raster_counter u_raster (
        .clock    (clock),
        .reset    (reset),
        .scale    (scale_q),
        .step     (step_p0),
        .clear    (clear_p0),
        .ox       (ox_p0),
        .oy       (oy_p0),
        .src_addr (src_addr_p0),
        .last     (last_p0)
    );

    assign clear_p0 = (state == IDLE);
    assign step_p0  = (state == DRAW) && !stall;
    assign px_p0    = POS_W'(x_q) + $signed(POS_W'(ox_p0));
    assign py_p0    = POS_W'(y_q) + $signed(POS_W'(oy_p0));

    // Stage B: storage data arrives; decide the write and apply backpressure.
    assign fb_w_en   = vld_p1 && (sprite_r0_data != TRANSPARENT_IDX) && on_screen(px_p1, py_p1);
    assign fb_w_data = vld_p1 ? sprite_r0_data : 4'd0;
    assign fb_w_addr = fb_index(px_p1, py_p1);
    assign stall     = fb_w_en && !fb_ready;

    // While stalled, re-present stage B's address so the read data stays valid.
    assign sprite_r0_select = id_q;
    assign sprite_r0_addr   = stall ? src_addr_p1 : src_addr_p0;

    assign dequeue = (state == IDLE) && !is_empty;
    assign busy    = (state != IDLE);

    // Control FSM and stage A -> stage B pipeline register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            id_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            scale_q     <= '0;
            px_p1       <= '0;
            py_p1       <= '0;
            src_addr_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!is_empty) begin
                        id_q    <= sprite_id[SEL_W-1:0];
                        x_q     <= $signed(sprite_x);
                        y_q     <= $signed(sprite_y);
                        scale_q <= sprite_scale;
                        if (sprite_id >= 8'(SPRITE_NUM) || sprite_scale == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (!stall) begin
                        px_p1       <= px_p0;
                        py_p1       <= py_p0;
                        src_addr_p1 <= src_addr_p0;
                        vld_p1      <= 1'b1;
                        if (last_p0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        vld_p1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
